// File: rtl/pad_pkg.sv
// Shared constants and helpers for the pad synchroniser/filter block.
package pad_pkg;

  localparam int unsigned DEF_N_IN        = 5;
  localparam int unsigned DEF_N_OUT       = 1;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_LEN    = 3;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pad_sync_chan.sv
// One input channel: synchroniser chain, stability filter and edge pulse generation.
module pad_sync_chan
  import pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic bypass,
  input  logic pad_in,
  output logic filt_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned         CNT_W    = clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   byp_q, byp_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Next-state: counter only runs in filter mode and restarts after any bypass change.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
    cnt_d  = '0;
    filt_d = filt_q;
    byp_d  = bypass;
    if (bypass) begin
      filt_d = sync;
    end else if (!byp_q && (sync != filt_q)) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      filt_q <= RST_VAL;
      byp_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      byp_q  <= byp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_out = filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/pad_sync_filter.sv
// Pad interface: filtered, synchronised input channels plus registered output pad drive.
module pad_sync_filter
  import pad_pkg::*;
#(
  parameter int unsigned     N_IN        = DEF_N_IN,
  parameter int unsigned     N_OUT       = DEF_N_OUT,
  parameter int unsigned     SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned     FILT_LEN    = DEF_FILT_LEN,
  parameter logic [N_IN-1:0] IN_RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bypass,
  input  logic [N_IN-1:0]  pad_in,
  output logic [N_IN-1:0]  filt_out,
  output logic [N_IN-1:0]  rise,
  output logic [N_IN-1:0]  fall,
  input  logic [N_OUT-1:0] core_out,
  input  logic [N_OUT-1:0] core_oe,
  output logic [N_OUT-1:0] pad_out,
  output logic [N_OUT-1:0] pad_oe
);

  for (genvar i = 0; i < int'(N_IN); i++) begin : g_chan
    pad_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_VAL     (IN_RST_VAL[i])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .bypass   (bypass),
      .pad_in   (pad_in[i]),
      .filt_out (filt_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  logic [N_OUT-1:0] pad_out_q, pad_out_d;
  logic [N_OUT-1:0] pad_oe_q, pad_oe_d;

  // Output pads are a straight one-cycle retiming of the core signals.
  always_comb begin
    pad_out_d = core_out;
    pad_oe_d  = core_oe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
    end
  end

  assign pad_out = pad_out_q;
  assign pad_oe  = pad_oe_q;

endmodule

// File: tb/tb_pad_sync_filter.sv
// Scoreboard bench for pad_sync_filter: reference model pushes expectations, monitor compares.
module tb_pad_sync_filter;

  localparam int unsigned    N_IN    = 5;
  localparam int unsigned    N_OUT   = 1;
  localparam int unsigned    SYNC    = 2;
  localparam int unsigned    FILT    = 3;
  localparam logic [N_IN-1:0] RST_VAL = 5'b00100;

  logic             clk = 1'b0;
  logic             rst;
  logic             bypass;
  logic [N_IN-1:0]  pad_in;
  logic [N_IN-1:0]  filt_out, rise, fall;
  logic [N_OUT-1:0] core_out, core_oe, pad_out, pad_oe;

  always #5 clk = ~clk;

  pad_sync_filter #(
    .N_IN        (N_IN),
    .N_OUT       (N_OUT),
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT),
    .IN_RST_VAL  (RST_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bypass   (bypass),
    .pad_in   (pad_in),
    .filt_out (filt_out),
    .rise     (rise),
    .fall     (fall),
    .core_out (core_out),
    .core_oe  (core_oe),
    .pad_out  (pad_out),
    .pad_oe   (pad_oe)
  );

  typedef struct packed {
    logic [N_IN-1:0]  filt;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  fall;
    logic [N_OUT-1:0] po;
    logic [N_OUT-1:0] poe;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: pad level delayed by SYNC cycles; a new level is accepted once it
  // has disagreed with the output for FILT consecutive filter-mode cycles.
  logic [N_IN-1:0] m_pipe [SYNC];
  logic [N_IN-1:0] m_filt;
  int              m_run  [N_IN];
  logic            m_byp_prev;

  task automatic model_step();
    exp_t            e;
    logic [N_IN-1:0] s;
    logic [N_IN-1:0] nf;
    if (rst) begin
      for (int k = 0; k < int'(SYNC); k++) m_pipe[k] = RST_VAL;
      for (int i = 0; i < int'(N_IN); i++) m_run[i] = 0;
      m_filt     = RST_VAL;
      m_byp_prev = 1'b0;
      e.filt = RST_VAL;
      e.rise = '0;
      e.fall = '0;
      e.po   = '0;
      e.poe  = '0;
    end else begin
      s  = m_pipe[SYNC-1];
      nf = m_filt;
      for (int i = 0; i < int'(N_IN); i++) begin
        if (bypass) begin
          nf[i]    = s[i];
          m_run[i] = 0;
        end else if (m_byp_prev) begin
          m_run[i] = 0;
        end else if (s[i] != m_filt[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= int'(FILT)) begin
            nf[i]    = s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      e.rise = nf & ~m_filt;
      e.fall = ~nf & m_filt;
      e.filt = nf;
      m_filt = nf;
      for (int k = int'(SYNC) - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0]  = pad_in;
      m_byp_prev = bypass;
      e.po  = core_out;
      e.poe = core_oe;
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_filt_out", 32'(filt_out), 32'(e.filt));
      chk("sb_rise",     32'(rise),     32'(e.rise));
      chk("sb_fall",     32'(fall),     32'(e.fall));
      chk("sb_pad_out",  32'(pad_out),  32'(e.po));
      chk("sb_pad_oe",   32'(pad_oe),   32'(e.poe));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int lat, rcnt, fcnt, ev;
    logic f0, fr, fl;
    rst      = 1'b1;
    bypass   = 1'b0;
    pad_in   = RST_VAL;
    core_out = '0;
    core_oe  = '0;

    // Reset held for three cycles.
    step(3);
    chk("rst_filt_out", 32'(filt_out), 32'(RST_VAL));
    chk("rst_rise",     32'(rise), 32'd0);
    chk("rst_fall",     32'(fall), 32'd0);
    chk("rst_pad_oe",   32'(pad_oe), 32'd0);
    rst = 1'b0;
    step(1);
    chk("post_rst_pulses", 32'(rise | fall), 32'd0);

    // Clean rising edge on channel 0.
    pad_in[0] = 1'b1;
    lat = 0;
    rcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (filt_out[0] && lat == 0) lat = c;
      if (rise[0]) rcnt++;
    end
    chk("edge_latency", 32'(lat), 32'd5);
    chk("edge_rise_width", 32'(rcnt), 32'd1);

    // Two-cycle glitch on channel 1 must be swallowed.
    f0 = filt_out[1];
    pad_in[1] = 1'b1;
    step(2);
    pad_in[1] = 1'b0;
    ev = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (filt_out[1] != f0 || rise[1] || fall[1]) ev++;
    end
    chk("glitch_events", 32'(ev), 32'd0);

    // Bypass: channel 2 toggles every 4 cycles.
    bypass = 1'b1;
    step(4);
    lat = 0;
    rcnt = 0;
    fcnt = 0;
    for (int t = 0; t < 4; t++) begin
      f0 = filt_out[2];
      pad_in[2] = ~pad_in[2];
      for (int c = 1; c <= 4; c++) begin
        step(1);
        if (t == 0 && lat == 0 && filt_out[2] != f0) lat = c;
        fr = rise[2];
        fl = fall[2];
        if (fr) rcnt++;
        if (fl) fcnt++;
      end
    end
    chk("byp_latency", 32'(lat), 32'd3);
    chk("byp_rises", 32'(rcnt), 32'd2);
    chk("byp_falls", 32'(fcnt), 32'd2);
    bypass = 1'b0;
    step(4);

    // Reset in the middle of a count on channel 3.
    pad_in[3] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_filt3", 32'(filt_out[3]), 32'(RST_VAL[3]));
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (filt_out[3] && lat == 0) lat = c;
    end
    chk("midrst_restart_latency", 32'(lat), 32'd5);

    // Output path retiming.
    core_out = '1;
    core_oe  = '0;
    step(1);
    core_oe = '1;
    step(1);
    chk("out_pad_oe_hi", 32'(pad_oe), 32'd1);
    chk("out_pad_out",   32'(pad_out), 32'd1);
    core_oe = '0;
    step(1);
    chk("out_pad_oe_lo", 32'(pad_oe), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N_IN); i++)
        if ($urandom_range(0, 5) == 0) pad_in[i] = ~pad_in[i];
      if ($urandom_range(0, 59) == 0) bypass = ~bypass;
      rst      = ($urandom_range(0, 199) == 0);
      core_out = N_OUT'($urandom);
      core_oe  = N_OUT'($urandom);
      step(1);
    end
    rst = 1'b0;
    step(3);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
